// File: rtl/bin_to_bcd_pkg.sv
// Shared constants, FSM encoding and helpers for the bin_to_bcd8 converter.
// Optional feature macro: BIN_TO_BCD_LZ_BLANK_EN (leading-zero blanking).
package bin_to_bcd_pkg;

  localparam int BIN_W      = 32;
  localparam int NUM_DIGITS = 8;
  localparam int CNT_W      = $clog2(BIN_W);

  localparam logic [BIN_W-1:0] MAX_VAL  = 32'd99999999;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SHIFT  = 2'd1,
    UPDATE = 2'd2
  } state_t;

  // Digit enables for leading-zero blanking: a digit is lit when it or any
  // more significant digit is nonzero; the units digit is always lit.
  function automatic logic [NUM_DIGITS-1:0] lz_enable(
    input logic [4*NUM_DIGITS-1:0] digits
  );
    logic seen;
    seen = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      seen         = seen | (digits[4*i +: 4] != 4'd0);
      lz_enable[i] = seen;
    end
    lz_enable[0] = 1'b1;
  endfunction

endpackage

// File: rtl/bin_to_bcd8_add3.sv
// Double-dabble correction cell: a BCD nibble of 5 or more gets +3 so that
// the following left shift carries correctly into the next decimal digit.
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin_to_bcd8.sv
// Free-running 32-bit binary to 8-digit BCD converter (shift-and-add-3).
// One conversion every 34 clocks: LOAD (1) + SHIFT (32) + UPDATE (1).
// Inputs above 99999999 saturate to 99999999.
// Optional feature macro: BIN_TO_BCD_LZ_BLANK_EN -- when defined, en blanks
// leading zeros; otherwise en is constant 8'hFF.
module bin_to_bcd8
  import bin_to_bcd_pkg::*;
(
  input  logic        clk_100kHz,
  input  logic        rst_,
  input  logic [31:0] bin,
  output logic [3:0]  bcd0,
  output logic [3:0]  bcd1,
  output logic [3:0]  bcd2,
  output logic [3:0]  bcd3,
  output logic [3:0]  bcd4,
  output logic [3:0]  bcd5,
  output logic [3:0]  bcd6,
  output logic [3:0]  bcd7,
  output logic [7:0]  en
);

`ifdef BIN_TO_BCD_LZ_BLANK_EN
  localparam logic [NUM_DIGITS-1:0] EN_RESET = 8'h01;
`else
  localparam logic [NUM_DIGITS-1:0] EN_RESET = 8'hFF;
`endif

  state_t                           state, state_next;
  logic [CNT_W-1:0]                 cnt;
  logic [BIN_W-1:0]                 shreg;
  logic [4*NUM_DIGITS-1:0]          scratch;
  logic [4*NUM_DIGITS-1:0]          scratch_adj;
  logic [NUM_DIGITS-1:0][3:0]       digits_q;
  logic                             load_en;
  logic                             shift_en;
  logic                             update_en;

  // Add-3 correction on every scratch nibble, applied before each shift.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (scratch[4*g +: 4]),
      .dout (scratch_adj[4*g +: 4])
    );
  end

  // State register.
  always_ff @(posedge clk_100kHz) begin
    // NOTE: clocked state always uses non-blocking (<=) so every register
    // samples pre-edge values, independent of statement order.
    if (rst_) state <= LOAD;
    else      state <= state_next;
  end

  // Next-state logic: LOAD -> 32 x SHIFT -> UPDATE -> LOAD.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_next unassigned
    // (which would infer a latch).
    state_next = state;
    unique case (state)
      LOAD:    state_next = SHIFT;
      SHIFT:   if (cnt == LAST_CNT) state_next = UPDATE;
      UPDATE:  state_next = LOAD;
      default: state_next = LOAD;
    endcase
  end

  // Datapath strobes decoded from the current state.
  always_comb begin
    load_en   = 1'b0;
    shift_en  = 1'b0;
    update_en = 1'b0;
    unique case (state)
      LOAD:    load_en   = 1'b1;
      SHIFT:   shift_en  = 1'b1;
      UPDATE:  update_en = 1'b1;
      default: load_en   = 1'b1;
    endcase
  end

  // Shift counter: cleared in LOAD, counts the 32 SHIFT cycles.
  always_ff @(posedge clk_100kHz) begin
    if (rst_)          cnt <= '0;
    else if (load_en)  cnt <= '0;
    else if (shift_en) cnt <= cnt + 1'b1;
  end

  // Shift register and BCD scratch: saturating load, then add-3 and shift.
  always_ff @(posedge clk_100kHz) begin
    // NOTE: these working registers are reset as well; it costs little and
    // keeps them defined from the first cycle after reset.
    if (rst_) begin
      shreg   <= '0;
      scratch <= '0;
    end else if (load_en) begin
      shreg   <= (bin > MAX_VAL) ? MAX_VAL : bin;
      scratch <= '0;
    end else if (shift_en) begin
      {scratch, shreg} <= {scratch_adj, shreg} << 1;
    end
  end

  // Output registers: refreshed only in UPDATE, so they hold steady while
  // the next conversion is in progress.
  always_ff @(posedge clk_100kHz) begin
    if (rst_) begin
      digits_q <= '0;
      en       <= EN_RESET;
    end else if (update_en) begin
      digits_q <= scratch;
`ifdef BIN_TO_BCD_LZ_BLANK_EN
      en       <= lz_enable(scratch);
`else
      en       <= 8'hFF;
`endif
    end
  end

  assign bcd0 = digits_q[0];
  assign bcd1 = digits_q[1];
  assign bcd2 = digits_q[2];
  assign bcd3 = digits_q[3];
  assign bcd4 = digits_q[4];
  assign bcd5 = digits_q[5];
  assign bcd6 = digits_q[6];
  assign bcd7 = digits_q[7];

endmodule

// File: tb/tb_bin_to_bcd8.sv
// Self-checking bench for bin_to_bcd8. A cycle monitor keeps an expected
// copy of the outputs (reset values, or the decimal digits of the value
// sampled at the start of each 34-cycle conversion) and compares every cycle;
// scenario tasks add explicit checks against hand-written constants.
module tb_bin_to_bcd8;

  logic        clk_100kHz = 1'b0;
  logic        rst_       = 1'b1;
  logic [31:0] bin        = 32'd0;
  logic [3:0]  bcd0, bcd1, bcd2, bcd3, bcd4, bcd5, bcd6, bcd7;
  logic [7:0]  en;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef BIN_TO_BCD_LZ_BLANK_EN
  localparam logic [7:0] EN_RST = 8'h01;
  localparam bit         LZ     = 1'b1;
`else
  localparam logic [7:0] EN_RST = 8'hFF;
  localparam bit         LZ     = 1'b0;
`endif

  bin_to_bcd8 dut (
    .clk_100kHz (clk_100kHz),
    .rst_       (rst_),
    .bin        (bin),
    .bcd0       (bcd0),
    .bcd1       (bcd1),
    .bcd2       (bcd2),
    .bcd3       (bcd3),
    .bcd4       (bcd4),
    .bcd5       (bcd5),
    .bcd6       (bcd6),
    .bcd7       (bcd7),
    .en         (en)
  );

  always #5 clk_100kHz = ~clk_100kHz;

  wire [31:0] dut_digits = {bcd7, bcd6, bcd5, bcd4, bcd3, bcd2, bcd1, bcd0};

  // ---------------- reference model (plain decimal arithmetic) -----------
  function automatic longint sat_val(input logic [31:0] v);
    return (longint'(v) > 64'd99999999) ? 64'd99999999 : longint'(v);
  endfunction

  function automatic logic [31:0] model_digits(input logic [31:0] v);
    longint x;
    logic [31:0] r;
    x = sat_val(v);
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [7:0] model_en(input logic [31:0] v);
    longint x, p;
    logic [7:0] r;
    if (!LZ) return 8'hFF;
    x = sat_val(v);
    p = 1;
    for (int i = 0; i < 8; i++) begin
      r[i] = (i == 0) || (x >= p);
      p = p * 10;
    end
    return r;
  endfunction

  // ---------------- cycle monitor ----------------------------------------
  int          ph = 0;
  logic [31:0] sampled;
  logic [31:0] exp_digits;
  logic [7:0]  exp_en;
  logic        edge_rst;
  logic [31:0] edge_bin;
  int          cyc = 0;

  always @(posedge clk_100kHz) begin
    edge_rst = rst_;
    edge_bin = bin;
    cyc++;
    if (edge_rst) begin
      ph         = 0;
      exp_digits = '0;
      exp_en     = EN_RST;
    end else begin
      if (ph == 0)  sampled = edge_bin;
      if (ph == 33) begin
        exp_digits = model_digits(sampled);
        exp_en     = model_en(sampled);
      end
      ph = (ph == 33) ? 0 : ph + 1;
    end
    #1;
    n_cmp++;
    if (dut_digits !== exp_digits) begin
      n_bad++;
      if (n_bad < 30)
        $display("FAIL mon_digits cyc=%0d got=%h exp=%h", cyc, dut_digits, exp_digits);
    end
    n_cmp++;
    if (en !== exp_en) begin
      n_bad++;
      if (n_bad < 30)
        $display("FAIL mon_en cyc=%0d got=%h exp=%h", cyc, en, exp_en);
    end
  end

  // ---------------- scenarios ---------------------------------------------
  task automatic test_reset();
    @(negedge clk_100kHz) rst_ = 1'b1;
    repeat (2) @(negedge clk_100kHz);
    n_cmp++;
    if (dut_digits !== 32'h0 || en !== EN_RST) begin
      n_bad++;
      $display("FAIL reset got=%h/%h exp=%h/%h", dut_digits, en, 32'h0, EN_RST);
    end
  endtask

  task automatic test_reset_release();
    bin  = 32'd0;
    rst_ = 1'b0;
    repeat (40) @(negedge clk_100kHz);
    n_cmp++;
    if (dut_digits !== 32'h0 || en !== 8'h01 && LZ || en !== 8'hFF && !LZ) begin
      n_bad++;
      $display("FAIL release_zero got=%h/%h", dut_digits, en);
    end
  endtask

  // Apply a value, let two full conversions elapse, compare with constants.
  task automatic apply_and_check(input string name, input logic [31:0] v,
                                 input logic [31:0] want_d, input logic [7:0] want_en);
    @(negedge clk_100kHz) bin = v;
    repeat (70) @(negedge clk_100kHz);
    n_cmp++;
    if (dut_digits !== want_d || en !== want_en) begin
      n_bad++;
      $display("FAIL %s got=%h/%h exp=%h/%h", name, dut_digits, en, want_d, want_en);
    end
  endtask

  task automatic test_mixed();
    apply_and_check("mixed_12345678", 32'd12345678, 32'h12345678, 8'hFF);
  endtask

  task automatic test_blank();
    apply_and_check("blank_1230", 32'd1230, 32'h00001230, LZ ? 8'h0F : 8'hFF);
  endtask

  task automatic test_saturation();
    apply_and_check("max_99999999", 32'd99999999, 32'h99999999, 8'hFF);
    apply_and_check("sat_100000000", 32'd100000000, 32'h99999999, 8'hFF);
    apply_and_check("sat_ffffffff", 32'hFFFFFFFF, 32'h99999999, 8'hFF);
    apply_and_check("zero", 32'd0, 32'h0, LZ ? 8'h01 : 8'hFF);
  endtask

  task automatic test_random();
    logic [31:0] v;
    for (int i = 0; i < 16; i++) begin
      case (i % 4)
        0:       v = $urandom;
        1:       v = $urandom_range(0, 999);
        2:       v = $urandom_range(0, 99999);
        default: v = $urandom_range(0, 99999999);
      endcase
      apply_and_check("random", v, model_digits(v), model_en(v));
    end
  endtask

  // Ramp the input while conversions run; the monitor checks every update.
  task automatic test_ramp();
    @(negedge clk_100kHz) bin = 32'd0;
    for (int s = 0; s < 200; s++) begin
      repeat (10) @(negedge clk_100kHz);
      bin = bin + 32'd10;
    end
    repeat (70) @(negedge clk_100kHz);
    n_cmp++;
    if (bcd0 !== 4'd0) begin
      n_bad++;
      $display("FAIL ramp_units got=%0d exp=0", bcd0);
    end
  endtask

  task automatic test_abort();
    int k;
    bin = 32'd4242;
    repeat (70) @(negedge clk_100kHz);
    k = 0;
    while (!(ph >= 5 && ph <= 20) && k < 50) begin
      @(negedge clk_100kHz);
      k++;
    end
    n_cmp++;
    if (k >= 50) begin
      n_bad++;
      $display("FAIL abort_phase_wait got=timeout exp=mid_shift");
    end
    rst_ = 1'b1;
    @(posedge clk_100kHz);
    #1;
    n_cmp++;
    if (dut_digits !== 32'h0 || en !== EN_RST) begin
      n_bad++;
      $display("FAIL abort_reset got=%h/%h exp=%h/%h", dut_digits, en, 32'h0, EN_RST);
    end
    @(negedge clk_100kHz) rst_ = 1'b0;
    k = 0;
    while (k < 60) begin
      @(posedge clk_100kHz);
      #1;
      k++;
      if (dut_digits !== 32'h0) break;
    end
    n_cmp++;
    if (k != 34 || dut_digits !== 32'h00004242) begin
      n_bad++;
      $display("FAIL abort_first_update got=%0d cycles/%h exp=34 cycles/%h",
               k, dut_digits, 32'h00004242);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_reset_release();
    test_mixed();
    test_blank();
    test_saturation();
    test_random();
    test_ramp();
    test_abort();
    repeat (3) @(negedge clk_100kHz);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
